// File: rtl/serial_and_collector_if.sv
// serial_and_collector_if: bit-pair input and result-word output bundle for serial_and_collector; adds out_parity under SERIAL_AND_PARITY_EN
interface serial_and_collector_if #(parameter int N = 5);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  logic in_valid;
  logic in_ready;
  logic a_bit;
  logic b_bit;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] out_word;
  logic [CW-1:0] bit_cnt;
`ifdef SERIAL_AND_PARITY_EN
  logic out_parity;
  modport master (output in_valid, a_bit, b_bit, out_ready, input in_ready, out_valid, out_word, bit_cnt, out_parity);
  modport slave (input in_valid, a_bit, b_bit, out_ready, output in_ready, out_valid, out_word, bit_cnt, out_parity);
`else
  modport master (output in_valid, a_bit, b_bit, out_ready, input in_ready, out_valid, out_word, bit_cnt);
  modport slave (input in_valid, a_bit, b_bit, out_ready, output in_ready, out_valid, out_word, bit_cnt);
`endif
endinterface

// File: rtl/serial_and_collector.sv
// serial_and_collector: ANDs LSB-first bit pairs into an N-bit word handed off on valid/ready; SERIAL_AND_PARITY_EN adds out_parity
module serial_and_collector #(parameter int N = 5) (
  input logic clk,
  input logic rst,
  serial_and_collector_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_nx;
  logic [N-1:0] word_q;
  logic [CW-1:0] cnt_q;
  logic acc, last, take;
  assign acc = bus.in_valid & (state == COLLECT);
  assign take = bus.out_ready & (state == HOLD);
  assign last = cnt_q == CW'(N - 1);
  assign bus.out_word = word_q;
  assign bus.bit_cnt = cnt_q;
  // state register
  always_ff @(posedge clk)
    state <= rst ? COLLECT : state_nx;
  // next state: leave COLLECT on the Nth accept, leave HOLD on handoff
  always_comb
    state_nx = (state == COLLECT) ? ((acc && last) ? HOLD : COLLECT) : (bus.out_ready ? COLLECT : HOLD);
  // handshake flags decode the registered state only
  always_comb begin
    bus.in_ready = state == COLLECT;
    bus.out_valid = state == HOLD;
  end
  // word assembly and bit counter; counter wraps to 0 so it reads 0 in HOLD
  always_ff @(posedge clk)
    if (rst) begin
      word_q <= '0;
      cnt_q <= '0;
    end else if (acc) begin
      word_q[cnt_q] <= bus.a_bit & bus.b_bit;
      cnt_q <= last ? '0 : cnt_q + CW'(1);
    end else if (take) begin
      word_q <= '0;
    end
`ifdef SERIAL_AND_PARITY_EN
  logic par_q;
  assign bus.out_parity = par_q;
  // running parity tracks out_word since the word is zero on entry to COLLECT
  always_ff @(posedge clk)
    par_q <= rst ? 1'b0 : acc ? par_q ^ (bus.a_bit & bus.b_bit) : take ? 1'b0 : par_q;
`endif
endmodule

// File: doc/serial_and_collector.md
Name: serial_and_collector

Overview:
- Bit-serial counterpart of the bit-parallel n-bit AND array.
- Accepts one operand bit pair (a_bit, b_bit) per handshake, LSB first, and ANDs the pair.
- Assembles N result bits into a parallel word and presents it on a valid/ready output port.
- Placed where operands arrive over a serial link and a parallel AND result is consumed downstream.

Parameters:
- N, 5, result word width and number of bit pairs per word; legal range N >= 2.
- CW, $clog2(N) (minimum 1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream bit pair valid
- in_ready  output  1  block can accept a bit pair this cycle
- a_bit  input  1  serial operand A bit, LSB first
- b_bit  input  1  serial operand B bit, LSB first
- out_valid  output  1  out_word holds a complete result
- out_ready  input  1  downstream accepts out_word
- out_word  output  N  assembled AND result; bit i = a_i & b_i
- bit_cnt  output  CW  number of bits collected in the current word (0..N-1)

Behaviour:
- One clock; reset is synchronous and active-high.
- Everything is sampled on the rising edge of clk.
- Reset (rst=1 at an edge): state=COLLECT, bit_cnt=0, out_word=0, out_valid=0, in_ready=1 from the next cycle.
  - rst has priority over every other input.
- Reset mid-word or while holding a result discards the partial or held word; no out_valid pulse is emitted.
- States: COLLECT, HOLD.
- COLLECT:
  - in_ready=1, out_valid=0.
  - Input accept = in_valid & in_ready.
  - On accept: out_word[bit_cnt] <= a_bit & b_bit.
  - If bit_cnt < N-1: bit_cnt <= bit_cnt+1.
  - If bit_cnt == N-1: bit_cnt <= 0, go to HOLD.
  - in_valid=0: no change. Gaps between bits are allowed without limit.
  - Bits not yet written in the current word read as 0 (out_word is cleared on entry to COLLECT).
- HOLD:
  - in_ready=0, out_valid=1, out_word stable.
  - bit_cnt reads 0 while in HOLD.
  - out_valid & out_ready at an edge: out_word <= 0, go to COLLECT.
  - out_ready=0: stay in HOLD indefinitely (backpressure). in_valid is ignored.
- Latency: out_valid rises on the first cycle after the edge that accepts the Nth bit.
  - Minimum word period is N+1 cycles (N accepts plus 1 handoff cycle).
- Simultaneous events:
  - In HOLD with out_ready=1 and in_valid=1, the bit is NOT accepted that cycle (in_ready=0).
  - That bit is accepted on the next cycle, in COLLECT.
- in_ready and out_valid are registered state decodes; neither is combinationally dependent on inputs.
- out_valid and in_ready are never both 1.
- N=5 wrap: bit_cnt sequence 0,1,2,3,4,0. No value >= N is ever reached.

Optional Feature:
- Macro: SERIAL_AND_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = XOR of all out_word bits.
  - Registered; updated with each accepted bit.
  - Valid whenever out_valid=1; reset value 0; cleared with out_word.
- Not defined: port absent; no parity logic.

Test Plan:
- Basic word: N=5, rst then a LSB-first 0,1,0,0,1 and b 1,1,1,0,0 on 5 consecutive cycles, out_ready=1 -> out_valid=1 one cycle after the 5th accept with out_word=5'b00010; cleared next cycle; in_ready=1 again.
- Word set: a=5'b01110/b=5'b11111, a=5'b00000/b=5'b00111, a=5'b10110/b=5'b11000, sent back to back with in_valid held high -> out_word=01110, 00000, 10000 in order. Each out_valid lasts 1 cycle and word period is 6 cycles.
- Backpressure: out_ready=0 for 10 cycles after a complete word, in_valid=1 throughout -> out_valid stays 1, out_word unchanged, in_ready=0, no bits consumed. Raising out_ready lets the next bit accept one cycle later.
- Gaps: in_valid toggles 1,0,0,1,0,1,1,0,1 with a=b=1 on valid cycles -> bit_cnt steps only on accepts; out_word=5'b11111 after the 5th accept.
- Reset mid-operation: rst=1 after 3 accepted bits -> next cycle bit_cnt=0, out_word=0, out_valid=0. The following 5 bits form a fresh correct word.
- With SERIAL_AND_PARITY_EN: a=5'b10110, b=5'b11000 -> out_word=10000, out_parity=1. With a=5'b01110, b=5'b11111 -> out_word=01110, out_parity=1. With a=5'b00011, b=5'b00011 -> out_word=00011, out_parity=0.
